fetch_stage: RTL and testbench

// - Instruction fetch stage: owns the PC, issues word reads to instruction memory over a req/gnt/rvalid handshake,
//   and drives the pc/instruction pair captured by the fetch-to-decode pipeline register every cycle.
// - Handles decode-stall hold, execute-stage branch/jump redirect, and discard of in-flight responses.
// - The downstream register has no enable, so this stage re-presents the same pc/instruction while stalled.
// - When it has nothing valid to present, it drives a NOP bubble.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_hold_buffer.sv | 34 +++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] fetch_next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry holding register for a fetched pc/instruction pair that
// arrived while decode was stalled. Clear takes priority over load.
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       clear,
  input  fetch_pkt_t din,
  output fetch_pkt_t dout,
  output logic       valid
);

  fetch_pkt_t pkt_q;
  logic       valid_q;

  // Capture a packet on load; drop it on clear or reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      pkt_q   <= din;
      valid_q <= 1'b1;
    end
  end

  assign dout  = pkt_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/gnt/rvalid handshake and drives the pc/instruction pair into the
// enable-less fetch-to-decode register every cycle (re-presenting it when
// stalled, NOP bubble when idle). Redirects from execute discard any
// in-flight response. Define FETCH_PERF_EN to add fetchCount/stallCycles.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        instValid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCycles
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic         inst_valid_q, inst_valid_d;
  logic         buf_load, buf_clear, buf_valid;
  logic         deliver;
  fetch_pkt_t   buf_in, buf_out;

  assign buf_in = '{pc: pc_q, inst: imemRdata};

  fetch_hold_buffer u_hold_buffer (
    .clock (clock),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (buf_in),
    .dout  (buf_out),
    .valid (buf_valid)
  );

  // Request only while waiting for a grant; address is the PC register.
  assign imemReq  = (state_q == REQ) && !reset;
  assign imemAddr = pc_q;

  // Next-state, PC and output-register selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    pc_out_d     = pc_out_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = inst_valid_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    deliver      = 1'b0;

    // With decode free and nothing new to present, drive a bubble.
    if (!stall) begin
      inst_out_d   = NOP_INSTR;
      inst_valid_d = 1'b0;
    end

    if (redirectValid) begin
      // Redirect wins over stall in every state.
      pc_d         = {redirectPc[31:2], 2'b00};
      inst_out_d   = NOP_INSTR;
      inst_valid_d = 1'b0;
      buf_clear    = 1'b1;
      // A granted-but-unanswered read must be swallowed when it returns.
      if ((state_q == REQ && imemGnt) || (state_q == WAIT && !imemRvalid)) begin
        discard_d = 1'b1;
        state_d   = WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = REQ;
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (imemGnt) state_d = WAIT;
        end
        WAIT: begin
          if (imemRvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = REQ;
            end else if (!stall) begin
              pc_out_d     = pc_q;
              inst_out_d   = imemRdata;
              inst_valid_d = 1'b1;
              pc_d         = fetch_next_pc(pc_q);
              deliver      = 1'b1;
              state_d      = REQ;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && buf_valid) begin
            pc_out_d     = buf_out.pc;
            inst_out_d   = buf_out.inst;
            inst_valid_d = 1'b1;
            buf_clear    = 1'b1;
            pc_d         = fetch_next_pc(pc_q);
            deliver      = 1'b1;
            state_d      = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // State, PC and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      pc_out_q     <= 32'h0;
      inst_out_q   <= NOP_INSTR;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign pcOut     = pc_out_q;
  assign instOut   = inst_out_q;
  assign instValid = inst_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_cycles_q;

  // Free-running, wrapping event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q  <= 32'h0;
      stall_cycles_q <= 32'h0;
    end else begin
      if (deliver) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall)   stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign fetchCount  = fetch_count_q;
  assign stallCycles = stall_cycles_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A behavioural memory answers reads
// (configurable or random grant/response delays) and a program-order
// scoreboard inside tick() checks every delivered pc/instruction, stall
// holds, redirect bubbles and request stability.
// Define FETCH_PERF_EN to also exercise the performance counters.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] FIRST = 32'h0050_0093;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic        instValid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCycles;
`endif

  int total = 0;
  int bad   = 0;

  // Memory model state.
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  bit          rand_mem  = 0;
  bit          pend      = 0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt  = 0;
  int          req_wait  = 0;

  // Scoreboard state.
  bit          sb_on      = 0;
  logic [31:0] exp_pc     = 32'h0;
  int          deliveries = 0;

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemGnt       (imemGnt),
    .imemRvalid    (imemRvalid),
    .imemRdata     (imemRdata),
    .pcOut         (pcOut),
    .instOut       (instOut),
    .instValid     (instValid)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount    (fetchCount),
    .stallCycles   (stallCycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Program image: address 0 holds addi x1,x0,5, everything else a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return FIRST;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  // One clock: drive memory at negedge, then check the edge's outcome.
  task automatic tick();
    logic        g, rv, e_reset, e_stall, e_redir, e_req, o_valid;
    logic [31:0] e_addr, e_target, o_pc, o_inst;
    @(negedge clock);
    g  = imemReq && (req_wait >= gnt_delay);
    rv = pend && (pend_cnt <= 1);
    imemGnt    = g;
    imemRvalid = rv;
    imemRdata  = rv ? mem_word(pend_addr) : $urandom();
    e_reset  = reset;
    e_stall  = stall;
    e_redir  = redirectValid;
    e_target = {redirectPc[31:2], 2'b00};
    e_req    = imemReq;
    e_addr   = imemAddr;
    o_pc     = pcOut;
    o_inst   = instOut;
    o_valid  = instValid;
    @(posedge clock);
    #1;
    if (e_reset) begin
      pend     = 0;
      req_wait = 0;
      exp_pc   = 32'h0;
    end else begin
      if (rv) pend = 0;
      else if (pend) pend_cnt--;
      if (g) begin
        if (rand_mem) begin
          rv_delay  = $urandom_range(1, 3);
          gnt_delay = $urandom_range(0, 2);
        end
        pend      = 1;
        pend_addr = e_addr;
        pend_cnt  = rv_delay;
        req_wait  = 0;
      end else if (e_req) begin
        req_wait++;
      end
    end
    if (sb_on && !e_reset) begin
      if (e_req && !g && !e_redir) begin
        total++;
        if (imemReq !== 1'b1 || imemAddr !== e_addr) begin
          bad++;
          $display("FAIL req_stable: req=%b addr=%h, required req=1 addr=%h",
                   imemReq, imemAddr, e_addr);
        end
      end
      if (e_redir) begin
        total++;
        if (instValid !== 1'b0 || instOut !== NOP) begin
          bad++;
          $display("FAIL redirect_bubble: valid=%b inst=%h, required valid=0 inst=%h",
                   instValid, instOut, NOP);
        end
        exp_pc = e_target;
      end else if (e_stall) begin
        total++;
        if (pcOut !== o_pc || instOut !== o_inst || instValid !== o_valid) begin
          bad++;
          $display("FAIL stall_hold: got pc=%h inst=%h v=%b, required pc=%h inst=%h v=%b",
                   pcOut, instOut, instValid, o_pc, o_inst, o_valid);
        end
      end else if (instValid === 1'b1) begin
        total++;
        if (pcOut !== exp_pc || instOut !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                   pcOut, instOut, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        total++;
        if (instOut !== NOP || pcOut !== o_pc) begin
          bad++;
          $display("FAIL idle_bubble: got pc=%h inst=%h, required pc=%h inst=%h",
                   pcOut, instOut, o_pc, NOP);
        end
      end
    end
  endtask

  task automatic run_until_out(input logic [31:0] pc, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (instValid === 1'b1 && pcOut === pc) found = 1;
    end
  endtask

  task automatic run_until_req(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (imemReq === 1'b1) found = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirectValid = 1'b0; redirectPc = 32'h0;
    imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = 32'h0;
    tick();
    tick();
    total++;
    if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req: got %b, required 0", imemReq); end
    total++;
    if (pcOut !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h, required 0", pcOut); end
    total++;
    if (instOut !== NOP) begin
      bad++; $display("FAIL reset_inst: got %h, required %h", instOut, NOP);
    end
    total++;
    if (instValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", instValid); end
    reset = 1'b0;
    sb_on = 1;
    #1;
    total++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      bad++; $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=0", imemReq, imemAddr);
    end
  endtask

  task automatic test_first_fetch();
    tick();
    total++;
    if (imemReq !== 1'b0) begin bad++; $display("FAIL first_wait_req: got %b, required 0", imemReq); end
    tick();
    total++;
    if (instOut !== FIRST || pcOut !== 32'h0 || instValid !== 1'b1) begin
      bad++; $display("FAIL first_out: got pc=%h inst=%h v=%b, required pc=0 inst=%h v=1",
                      pcOut, instOut, instValid, FIRST);
    end
    total++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin
      bad++; $display("FAIL first_next_addr: req=%b addr=%h, required req=1 addr=4", imemReq, imemAddr);
    end
  endtask

  task automatic test_stall();
    bit found;
    run_until_out(32'h8, 20, found);
    total++;
    if (!found) begin bad++; $display("FAIL stall_reach_pc8: not seen, required pc=8"); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pcOut !== 32'h8 || instOut !== mem_word(32'h8) || instValid !== 1'b1) begin
        bad++; $display("FAIL stall_pc8_held: cycle %0d got pc=%h inst=%h v=%b, required pc=8 inst=%h v=1",
                        i, pcOut, instOut, instValid, mem_word(32'h8));
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (pcOut !== 32'hC || instOut !== mem_word(32'hC) || instValid !== 1'b1) begin
      bad++; $display("FAIL stall_release: got pc=%h inst=%h v=%b, required pc=c inst=%h v=1",
                      pcOut, instOut, instValid, mem_word(32'hC));
    end
    run_until_out(32'h10, 10, found);
    total++;
    if (!found) begin bad++; $display("FAIL stall_next_pc16: not seen, required pc=10"); end
  endtask

  task automatic test_redirect_wait();
    bit found;
    rv_delay = 3;
    tick();
    total++;
    if (imemReq !== 1'b0) begin bad++; $display("FAIL redir_in_wait: req=%b, required 0", imemReq); end
    redirectValid = 1'b1;
    redirectPc    = 32'h100;
    tick();
    redirectValid = 1'b0;
    rv_delay      = 1;
    total++;
    if (instValid !== 1'b0 || instOut !== NOP) begin
      bad++; $display("FAIL redir_wait_bubble: v=%b inst=%h, required v=0 inst=%h", instValid, instOut, NOP);
    end
    run_until_req(10, found);
    total++;
    if (!found || imemAddr !== 32'h100) begin
      bad++; $display("FAIL redir_wait_addr: found=%0d addr=%h, required addr=100", found, imemAddr);
    end
    run_until_out(32'h100, 10, found);
    total++;
    if (!found) begin bad++; $display("FAIL redir_wait_deliver: not seen, required pc=100"); end
  endtask

  task automatic test_redirect_stall();
    bit found;
    stall         = 1'b1;
    redirectValid = 1'b1;
    redirectPc    = 32'h200;
    tick();
    redirectValid = 1'b0;
    total++;
    if (instValid !== 1'b0 || instOut !== NOP) begin
      bad++; $display("FAIL redir_stall_bubble: v=%b inst=%h, required v=0 inst=%h", instValid, instOut, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (instValid !== 1'b0 || instOut !== NOP) begin
        bad++; $display("FAIL redir_stall_held: cycle %0d v=%b inst=%h, required v=0 inst=%h",
                        i, instValid, instOut, NOP);
      end
    end
    stall = 1'b0;
    run_until_out(32'h200, 10, found);
    total++;
    if (!found || instOut !== mem_word(32'h200)) begin
      bad++; $display("FAIL redir_stall_resume: found=%0d inst=%h, required pc=200 inst=%h",
                      found, instOut, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap_and_slow_gnt();
    bit found;
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFFC;
    tick();
    redirectValid = 1'b0;
    run_until_out(32'hFFFF_FFFC, 20, found);
    total++;
    if (!found) begin bad++; $display("FAIL wrap_top: not seen, required pc=fffffffc"); end
    gnt_delay = 5;
    total++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: req=%b addr=%h, required req=1 addr=0", imemReq, imemAddr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
        bad++; $display("FAIL slow_gnt_stable: cycle %0d req=%b addr=%h, required req=1 addr=0",
                        i, imemReq, imemAddr);
      end
    end
    run_until_out(32'h0, 10, found);
    gnt_delay = 0;
    total++;
    if (!found || instOut !== FIRST) begin
      bad++; $display("FAIL slow_gnt_deliver: found=%0d inst=%h, required pc=0 inst=%h", found, instOut, FIRST);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    rv_delay = 4;
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (imemReq !== 1'b0 || instValid !== 1'b0 || instOut !== NOP || pcOut !== 32'h0) begin
      bad++; $display("FAIL mid_reset_state: req=%b v=%b inst=%h pc=%h, required 0/0/%h/0",
                      imemReq, instValid, instOut, pcOut, NOP);
    end
    reset    = 1'b0;
    rv_delay = 1;
    run_until_out(32'h0, 10, found);
    total++;
    if (!found || instOut !== FIRST) begin
      bad++; $display("FAIL mid_reset_restart: found=%0d inst=%h, required pc=0 inst=%h", found, instOut, FIRST);
    end
  endtask

  task automatic test_random();
    int start;
    start    = deliveries;
    rand_mem = 1;
    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      redirectValid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirectPc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else redirectPc = $urandom() & 32'h0000_0FFF;
      tick();
    end
    stall         = 1'b0;
    redirectValid = 1'b0;
    rand_mem      = 0;
    gnt_delay     = 0;
    rv_delay      = 1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (deliveries - start < 30) begin
      bad++; $display("FAIL random_progress: got %0d deliveries, required at least 30", deliveries - start);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int  n;
    logic s;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (fetchCount !== 32'h0 || stallCycles !== 32'h0) begin
      bad++; $display("FAIL perf_reset: fetch=%0d stall=%0d, required 0/0", fetchCount, stallCycles);
    end
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      stall = (i >= 5 && i < 9);
      s     = stall;
      tick();
      if (!s && instValid === 1'b1) n++;
    end
    stall = 1'b0;
    total++;
    if (n != 10 || fetchCount !== 32'd10 || stallCycles !== 32'd4) begin
      bad++; $display("FAIL perf_counts: n=%0d fetch=%0d stall=%0d, required 10/10/4",
                      n, fetchCount, stallCycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap_and_slow_gnt();
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
